// File: rtl/carrier_nco.sv
// Carrier NCO: center frequency plus latched loop offset drives a 32-bit phase
// accumulator; quarter-wave table with quadrant fold yields sin/cos for the DDC mixer.
module carrier_nco #(
  parameter int OUT_W  = 10,
  parameter int LUT_AW = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clkEn,
  input  logic                    cs,
  input  logic [1:0]              addr,
  input  logic                    wr0,
  input  logic                    wr1,
  input  logic                    wr2,
  input  logic                    wr3,
  input  logic [31:0]             din,
  output logic [31:0]             dout,
  input  logic [31:0]             carrierFreqOffset,
  input  logic                    carrierFreqEn,
  output logic [31:0]             freqWord,
  output logic [7:0]              ncoPhase,
  output logic signed [OUT_W-1:0] ncoSin,
  output logic signed [OUT_W-1:0] ncoCos,
  output logic                    ncoValid,
  output logic                    wrapPulse
);
  localparam int STAGES = 2;

  // round(511*sin(2*pi*(k+0.5)/256)); never 0 or 512, so negation is safe
  localparam int LUT [64] = '{
      6,  19,  31,  44,  56,  69,  81,  94, 106, 118, 130, 142, 154, 166, 178, 190,
    201, 213, 224, 235, 246, 257, 268, 279, 289, 299, 309, 319, 329, 338, 348, 357,
    366, 374, 383, 391, 399, 407, 414, 421, 428, 435, 441, 448, 454, 459, 465, 470,
    474, 479, 483, 487, 491, 494, 497, 500, 502, 505, 506, 508, 509, 510, 511, 511};

  logic [31:0]       centerFreq, phaseOffset, offsetReg, phaseAccum;
  logic              offsetEn, holdOffset;
  logic [3:0]        byteWr;
  logic              clearPhase;
  logic [STAGES-1:0] vldPipe;
  logic              wrapS1;

  assign byteWr     = {wr3, wr2, wr1, wr0} & {4{cs}};
  assign clearPhase = byteWr[0] && (addr == 2'd1) && din[2];

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      centerFreq  <= '0;
      phaseOffset <= '0;
      offsetEn    <= 1'b0;
      holdOffset  <= 1'b0;
      offsetReg   <= '0;
      freqWord    <= '0;
    end else begin
      if (addr == 2'd0) centerFreq  <= mergeBytes(centerFreq, din, byteWr);
      if (addr == 2'd2) phaseOffset <= mergeBytes(phaseOffset, din, byteWr);
      if (addr == 2'd1 && byteWr[0]) {holdOffset, offsetEn} <= din[1:0];
      if (carrierFreqEn && !holdOffset) offsetReg <= carrierFreqOffset;
      freqWord <= centerFreq + (offsetEn ? offsetReg : 32'd0);
    end
  end

  always_comb begin
    dout = '0;
    if (cs) begin
      case (addr)
        2'd0:    dout = centerFreq;
        2'd1:    dout = {30'd0, holdOffset, offsetEn};
        2'd2:    dout = phaseOffset;
        default: dout = freqWord;
      endcase
    end
  end

  // A negative word wraps when the add does not carry (borrow below zero)
  logic [32:0] accSum;
  logic        wrapDet;
  assign accSum  = {1'b0, phaseAccum} + {1'b0, freqWord};
  assign wrapDet = (freqWord != '0) && (freqWord[31] ? !accSum[32] : accSum[32]);

  always_ff @(posedge clk) begin
    if (reset) begin
      phaseAccum <= '0;
      vldPipe    <= '0;
      wrapS1     <= 1'b0;
    end else begin
      vldPipe <= {vldPipe[STAGES-2:0], clkEn};
      wrapS1  <= clkEn && wrapDet && !clearPhase;
      if (clearPhase)  phaseAccum <= '0;
      else if (clkEn)  phaseAccum <= accSum[31:0];
    end
  end

  logic [31:0]             p;
  logic [1:0]              quad;
  logic [LUT_AW-1:0]       fIdx;
  logic signed [OUT_W-1:0] lutF, lutR;

  assign p    = phaseAccum + phaseOffset;
  assign quad = p[31:30];
  assign fIdx = p[29 -: LUT_AW];
  assign lutF = OUT_W'(LUT[fIdx]);
  assign lutR = OUT_W'(LUT[~fIdx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      ncoPhase  <= '0;
      ncoSin    <= '0;
      ncoCos    <= '0;
      wrapPulse <= 1'b0;
    end else begin
      wrapPulse <= wrapS1;
      if (vldPipe[0]) begin
        ncoPhase <= p[31:24];
        case (quad)
          2'd0:    begin ncoSin <=  lutF; ncoCos <=  lutR; end
          2'd1:    begin ncoSin <=  lutR; ncoCos <= -lutF; end
          2'd2:    begin ncoSin <= -lutF; ncoCos <= -lutR; end
          default: begin ncoSin <= -lutR; ncoCos <=  lutF; end
        endcase
      end
    end
  end

  assign ncoValid = vldPipe[STAGES-1];
endmodule

// File: tb/tb_carrier_nco.sv
// Self-checking bench for carrier_nco: fold table, directed corner sequences and
// randomized traffic against a sample-level reference model.
module tb_carrier_nco;
  logic        clk = 1'b0;
  logic        reset, clkEn, cs, wr0, wr1, wr2, wr3, carrierFreqEn;
  logic [1:0]  addr;
  logic [31:0] din, dout, carrierFreqOffset, freqWord;
  logic [7:0]  ncoPhase;
  logic [9:0]  ncoSin, ncoCos;
  logic        ncoValid, wrapPulse;

  carrier_nco #(.OUT_W(10), .LUT_AW(6)) dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .cs(cs), .addr(addr),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3), .din(din), .dout(dout),
    .carrierFreqOffset(carrierFreqOffset), .carrierFreqEn(carrierFreqEn),
    .freqWord(freqWord), .ncoPhase(ncoPhase), .ncoSin(ncoSin), .ncoCos(ncoCos),
    .ncoValid(ncoValid), .wrapPulse(wrapPulse));

  always #5 clk = ~clk;

  int nChk = 0, nFail = 0;
  int lut [64];

  // reference model state
  logic [31:0] mCenter, mPhOff, mOffReg, mFw, mAcc;
  logic        mOffEn, mHold, pendV, pendW, mValid, mWrap;
  logic [7:0]  mPh;
  logic [9:0]  mSin, mCos;

  typedef struct { logic [31:0] phOff; logic [9:0] s; logic [9:0] c; logic [7:0] ph; } foldVec_t;
  foldVec_t fv [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fold(input logic [31:0] ph, output logic [9:0] s, output logic [9:0] c);
    int a, b, si, ci;
    a = lut[ph[29:24]];
    b = lut[63 - ph[29:24]];
    case (ph[31:30])
      2'd0:    begin si =  a; ci =  b; end
      2'd1:    begin si =  b; ci = -a; end
      2'd2:    begin si = -a; ci = -b; end
      default: begin si = -b; ci =  a; end
    endcase
    s = 10'(si);
    c = 10'(ci);
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    longint sum;
    logic [31:0] newFw, pp;
    logic [3:0] we;
    logic clr;
    @(posedge clk);
    we = {wr3, wr2, wr1, wr0} & {4{cs}};
    if (reset) begin
      {mCenter, mPhOff, mOffReg, mFw, mAcc} = '0;
      {mOffEn, mHold, pendV, pendW, mValid, mWrap} = '0;
      mPh = '0; mSin = '0; mCos = '0;
    end else begin
      if (pendV) begin
        pp = mAcc + mPhOff;
        fold(pp, mSin, mCos);
        mPh = pp[31:24];
        mValid = 1'b1;
        mWrap = pendW;
      end else begin
        mValid = 1'b0;
        mWrap = 1'b0;
      end
      clr = we[0] && addr == 2'd1 && din[2];
      // signed step: wrap means the phase left [0, 2^32) in either direction
      sum = longint'(mAcc) + (mFw[31] ? longint'(mFw) - 64'sh100000000 : longint'(mFw));
      pendW = clkEn && !clr && (sum < 0 || sum >= 64'sh100000000);
      pendV = clkEn;
      if (clr) mAcc = '0;
      else if (clkEn) mAcc = sum[31:0];
      newFw = mCenter + (mOffEn ? mOffReg : 32'd0);
      if (carrierFreqEn && !mHold) mOffReg = carrierFreqOffset;
      for (int i = 0; i < 4; i++) begin
        if (we[i] && addr == 2'd0) mCenter[8*i +: 8] = din[8*i +: 8];
        if (we[i] && addr == 2'd2) mPhOff[8*i +: 8]  = din[8*i +: 8];
      end
      if (we[0] && addr == 2'd1) begin mOffEn = din[0]; mHold = din[1]; end
      mFw = newFw;
    end
    #1;
    check("outputs", {ncoValid, wrapPulse, ncoPhase, ncoSin, ncoCos},
                     {mValid, mWrap, mPh, mSin, mCos});
    check("freqWord", freqWord, mFw);
  endtask

  task automatic idle();
    cs = 0; {wr3, wr2, wr1, wr0} = 4'b0; clkEn = 0; carrierFreqEn = 0;
    addr = 2'd0; din = '0; carrierFreqOffset = '0;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    cs = 1; addr = a; din = d; {wr3, wr2, wr1, wr0} = 4'hF;
    tick();
    cs = 0; {wr3, wr2, wr1, wr0} = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    cs = 1; addr = a; {wr3, wr2, wr1, wr0} = 4'h0;
    #1;
    check(name, dout, exp);
    cs = 0;
  endtask

  initial begin
    logic [7:0] expPh [5];
    logic       expW  [5];
    int got, budget;
    logic [31:0] modelRd;

    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi(511.0 * $sin(2.0 * 3.14159265358979 * (k + 0.5) / 256.0) + 0.5);

    fv[0] = '{32'h00000000, 10'd6,   10'd511, 8'h00};
    fv[1] = '{32'h40000000, 10'd511, 10'h3FA, 8'h40};
    fv[2] = '{32'h80000000, 10'h3FA, 10'h201, 8'h80};
    fv[3] = '{32'hC0000000, 10'h201, 10'd6,   8'hC0};
    fv[4] = '{32'h05000000, 10'd69,  10'd506, 8'h05};
    fv[5] = '{32'hBF000000, 10'h201, 10'h3FA, 8'hBF};

    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    rd(2'd0, 32'd0, "rst_center");
    rd(2'd1, 32'd0, "rst_ctrl");
    rd(2'd3, 32'd0, "rst_freqWord");

    // fold table: accumulator stays 0 (freqWord=0), phase set by phaseOffset
    for (int i = 0; i < 6; i++) begin
      wreg(2'd2, fv[i].phOff);
      clkEn = 1; tick();
      clkEn = 0; tick();
      check($sformatf("fold%0d", i), {ncoValid, ncoPhase, ncoSin, ncoCos},
                                     {1'b1, fv[i].ph, fv[i].s, fv[i].c});
    end
    wreg(2'd2, 32'd0);

    // quarter-turn steps
    wreg(2'd0, 32'h40000000);
    wreg(2'd1, 32'd0);
    clkEn = 1;
    repeat (14) tick();
    clkEn = 0;
    repeat (3) tick();

    // offset cancels center -> frozen phase
    wreg(2'd0, 32'h10000000);
    wreg(2'd1, 32'd1);
    carrierFreqEn = 1; carrierFreqOffset = 32'hF0000000;
    tick();
    carrierFreqEn = 0;
    tick();
    check("t3_fw_zero", freqWord, 32'd0);
    clkEn = 1;
    repeat (6) tick();
    clkEn = 0;

    // holdOffset blocks capture
    wreg(2'd1, 32'd3);
    carrierFreqEn = 1; carrierFreqOffset = 32'h12345678;
    tick();
    carrierFreqEn = 0;
    tick(); tick();
    rd(2'd3, 32'd0, "t4_fw_hold");

    // negative word with phase cleared first
    wreg(2'd1, 32'd0);
    wreg(2'd0, 32'hC0000000);
    wreg(2'd1, 32'd4);
    tick(); tick();
    expPh = '{8'hC0, 8'h80, 8'h40, 8'h00, 8'hC0};
    expW  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clkEn = 1;
    got = 0; budget = 0;
    while (got < 5 && budget < 20) begin
      tick();
      budget++;
      if (ncoValid) begin
        check($sformatf("t5_step%0d", got), {ncoPhase, wrapPulse}, {expPh[got], expW[got]});
        got++;
      end
    end
    check("t5_samples", got, 5);

    // clearPhase concurrent with clkEn
    cs = 1; addr = 2'd1; din = 32'd4; wr0 = 1;
    tick();
    cs = 0; wr0 = 0;
    tick();
    check("t6_clear_sample", {ncoValid, wrapPulse, ncoPhase}, {1'b1, 1'b0, 8'h00});
    tick();

    // reset mid-pipeline
    reset = 1; clkEn = 0;
    tick();
    reset = 0;
    repeat (3) tick();
    check("t6_reset_out", {ncoValid, wrapPulse, ncoPhase, ncoSin, ncoCos}, '0);
    rd(2'd0, 32'd0, "t6_reset_center");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      clkEn = ($urandom_range(0, 3) != 0);
      cs = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom_range(0, 3));
      din = $urandom;
      if (addr == 2'd1) din[2] = ($urandom_range(0, 7) == 0);
      {wr3, wr2, wr1, wr0} = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      carrierFreqEn = ($urandom_range(0, 5) == 0);
      carrierFreqOffset = $urandom;
      #1;
      case (addr)
        2'd0:    modelRd = mCenter;
        2'd1:    modelRd = {30'd0, mHold, mOffEn};
        2'd2:    modelRd = mPhOff;
        default: modelRd = mFw;
      endcase
      check("dout", dout, cs ? modelRd : 32'd0);
      tick();
    end
    idle(); reset = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
